cbus_rr_arbiter: RTL and testbench
==================================

Name: cbus_rr_arbiter

Overview:
- Shares the single cache bus (cbus) between NUM_INPUTS requesters: icache refill, dcache refill/writeback and the uncached dbus-to-cbus bridges.
- Picks one valid requester, grants it, then holds the grant for the whole transaction, including multi-beat bursts, until the final beat handshakes.
- Default policy is round-robin, so a streaming icache cannot starve uncached MMIO traffic. An optional fixed-priority mode is available.
- Sits between the cache/uncache front-ends and the top-level cbus port.

Parameters:
- NUM_INPUTS, 4, number of requesters; legal range 1..8.
- FIXED_PRIO, 0, 0 = round-robin; 1 = lowest index always wins.
- IDX_W, (NUM_INPUTS>1 ? $clog2(NUM_INPUTS) : 1), width of grant index; derived, not overridden.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low.
- ireqs  in  NUM_INPUTS x cbus_req_t  per-requester cbus requests; index 0 = packed LSB slot.
- iresps  out  NUM_INPUTS x cbus_resp_t  per-requester responses.
- oreq  out  cbus_req_t  request to memory side.
- oresp  in  cbus_resp_t  response from memory side (ready, last, data).
- grant_valid  out  1  a transaction is in progress.
- grant_idx  out  IDX_W  index of the current owner; 0 when idle.

Behaviour:
- Reset is one clock, asynchronous and active-low: resetn=0 clears all state immediately, without waiting for clk.
- Values while resetn=0:
  - state=IDLE, rr_ptr=0, grant_idx=0, grant_valid=0.
  - oreq='0 and every iresps[i]='0, combinationally.
- States:
  - IDLE: no owner.
  - BUSY: owner = grant_idx.
- IDLE behaviour:
  - oreq='0 and all iresps='0. No request is forwarded in the same cycle it is first seen.
  - Selection when any ireqs[i].valid=1:
    - FIXED_PRIO=0: the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_INPUTS.
    - FIXED_PRIO=1: the lowest valid index.
  - Registered on the clock edge: grant_idx<=winner, state<=BUSY.
  - No valid requests: stay IDLE.
- BUSY behaviour:
  - oreq = ireqs[grant_idx], passed through combinationally.
  - iresps[grant_idx] = oresp; every other iresps[j] = '0.
- BUSY exit, on the edge where oreq.valid & oresp.ready & oresp.last:
  - state<=IDLE.
  - rr_ptr<=grant_idx+1, wrapping to 0 at NUM_INPUTS. rr_ptr is left unchanged when FIXED_PRIO=1.
- Latency:
  - First valid at edge t (sampled in IDLE) gives oreq.valid in cycle t+1.
  - One mandatory IDLE cycle separates consecutive grants. Two back-to-back transactions are therefore separated by exactly one idle bus cycle.
- Owner drops valid mid-transaction: this is illegal for a requester. The arbiter still holds the grant, forwards valid=0, and releases only on a last handshake.
- oresp.last without oresp.ready: no release.
- oresp.ready/last while IDLE: ignored.
- Non-owner valid changes while BUSY have no effect. Those requesters see ready=0 and keep waiting.
- Simultaneous last handshake and new requests: the release happens first. The new requests are arbitrated in the following IDLE cycle using the updated rr_ptr.
- A single-beat transaction (len=0, last with the first ready) occupies BUSY for exactly the cycles until that handshake.
- NUM_INPUTS=1: the round-robin pointer stays 0 and the idle-gap behaviour is unchanged.
- Reset asserted mid-BUSY: the bus drops immediately (oreq.valid=0). Requesters are reset by the same signal, so no recovery logic is required.

Decomposition:
- cbus_req_t, cbus_resp_t and the cbus length/size encodings remain in the shared common package.
- Add a package constant CBUS_MAX_REQUESTERS=8 for the parameter legality check.
- One natural sub-module: rr_pick, a combinational rotate-priority-encoder (valid vector + pointer -> winner index + any). Fixed priority is obtained by tying its pointer to 0.

Test Plan:
- Single requester, i=2, 4-beat read (len=3): valid at edge 0 -> oreq.valid=1 from cycle 1; iresps[2] mirrors 4 data beats; grant_valid=0 the cycle after last; other iresps always 0.
- All 4 requesters hold valid continuously, single-beat each, FIXED_PRIO=0, rr_ptr=0 -> grant order 0,1,2,3,0 with one idle cycle between grants.
- Same stimulus with FIXED_PRIO=1 -> index 0 re-granted every time; index 3 never granted while 0 stays valid.
- Owner 1 mid-burst (beat 2 of 8) while requester 0 raises valid -> requester 0 stays at ready=0 until owner 1 completes its last beat, then is granted after one idle cycle.
- last=1 with ready=0 for 3 cycles, then ready=1 -> release only on the ready cycle; rr_ptr advances once.
- resetn pulled low mid-burst between clock edges -> oreq.valid=0 and grant_valid=0 immediately; after release, the first grant goes to the lowest valid index, since rr_ptr=0.

Source files
------------

// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared cbus types for the cache/uncache front-ends and the bus arbiter.
// Also holds the arbiter's state encoding.
package cbus_rr_arbiter_pkg;

  localparam int CBUS_MAX_REQUESTERS = 8;

  typedef enum logic [2:0] {
    CBUS_SIZE_1B = 3'd0,
    CBUS_SIZE_2B = 3'd1,
    CBUS_SIZE_4B = 3'd2
  } cbus_size_e;

  // Burst length is encoded as number of beats minus one.
  typedef logic [3:0] cbus_len_t;

  typedef struct packed {
    logic       valid;
    logic       is_write;
    logic [31:0] addr;
    cbus_size_e size;
    cbus_len_t  len;
    logic [31:0] data;
    logic [3:0] strb;
  } cbus_req_t;

  typedef struct packed {
    logic       ready;
    logic       last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// Rotating priority encoder: the first set bit of valid scanning from ptr
// upward, wrapping modulo N. Tie ptr to 0 for plain lowest-index priority.
module cbus_rr_arbiter_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // One extra bit so ptr+offset cannot overflow before the wrap.
  logic [IDX_W:0] cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int off = 0; off < N; off++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(N)) begin
        cand = cand - (IDX_W+1)'(N);
      end
      if (!any && valid[cand[IDX_W-1:0]]) begin
        any = 1'b1;
        idx = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// Shares the single cache bus between NUM_INPUTS requesters. A granted owner
// keeps the bus until its final beat handshakes; one idle cycle separates grants.
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int FIXED_PRIO = 0,
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  cbus_req_t  [NUM_INPUTS-1:0]  ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0]  iresps,
  output cbus_req_t                    oreq,
  input  cbus_resp_t                   oresp,
  output logic                         grant_valid,
  output logic [IDX_W-1:0]             grant_idx,
  output arb_state_e                   dbg_state,
  output logic [IDX_W-1:0]             dbg_rr_ptr
);

  if (NUM_INPUTS < 1 || NUM_INPUTS > CBUS_MAX_REQUESTERS) begin : g_bad_num_inputs
    $error("cbus_rr_arbiter: NUM_INPUTS out of range 1..8");
  end

  // Handshake: a beat moves on a cycle where oreq.valid and oresp.ready are
  // both high; if oresp.last is also high on that beat the transaction ends.

  arb_state_e       state, state_next;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_next;
  logic [IDX_W-1:0] grant_idx_next;
  logic [IDX_W-1:0] pick_ptr, pick_idx, ptr_after_owner;
  logic [NUM_INPUTS-1:0] req_valid;
  logic             pick_any;
  logic             release_bus;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      req_valid[i] = ireqs[i].valid;
    end
  end

  assign pick_ptr = (FIXED_PRIO != 0) ? '0 : rr_ptr;

  cbus_rr_arbiter_rr_pick #(
    .N     (NUM_INPUTS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .valid (req_valid),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign ptr_after_owner = (grant_idx == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_idx + 1'b1;
  assign release_bus     = oreq.valid && oresp.ready && oresp.last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ARB_IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_next;
      grant_idx <= grant_idx_next;
      rr_ptr    <= rr_ptr_next;
    end
  end

  always_comb begin
    state_next     = state;
    grant_idx_next = grant_idx;
    rr_ptr_next    = rr_ptr;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_next     = ARB_BUSY;
          grant_idx_next = pick_idx;
        end
      end
      ARB_BUSY: begin
        // An owner that drops valid mid-burst keeps the bus until a real last beat.
        if (release_bus) begin
          state_next     = ARB_IDLE;
          grant_idx_next = '0;
          if (FIXED_PRIO == 0) begin
            rr_ptr_next = ptr_after_owner;
          end
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    oreq   = '0;
    iresps = '0;
    if (state == ARB_BUSY) begin
      oreq              = ireqs[grant_idx];
      iresps[grant_idx] = oresp;
    end
  end

  assign grant_valid = (state == ARB_BUSY);
  assign dbg_state   = state;
  assign dbg_rr_ptr  = rr_ptr;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed bench for cbus_rr_arbiter: a round-robin and a fixed-priority
// instance share one stimulus stream; expectations are hand-computed.
module tb_cbus_rr_arbiter;
  import cbus_rr_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  typedef cbus_resp_t [N-1:0] resp_vec_t;

  logic             clk;
  logic             resetn;
  cbus_req_t [N-1:0] ireqs;
  cbus_resp_t       oresp;

  resp_vec_t        rr_iresps, fp_iresps;
  cbus_req_t        rr_oreq, fp_oreq;
  logic             rr_gv, fp_gv;
  logic [IW-1:0]    rr_gi, fp_gi;
  arb_state_e       rr_state, fp_state;
  logic [IW-1:0]    rr_ptr, fp_ptr;

  int checks = 0;
  int errors = 0;
  int order_rr [5] = '{0, 1, 2, 3, 0};

  cbus_rr_arbiter #(.NUM_INPUTS(N), .FIXED_PRIO(0)) u_rr (
    .clk (clk), .resetn (resetn), .ireqs (ireqs), .iresps (rr_iresps),
    .oreq (rr_oreq), .oresp (oresp), .grant_valid (rr_gv), .grant_idx (rr_gi),
    .dbg_state (rr_state), .dbg_rr_ptr (rr_ptr)
  );

  cbus_rr_arbiter #(.NUM_INPUTS(N), .FIXED_PRIO(1)) u_fp (
    .clk (clk), .resetn (resetn), .ireqs (ireqs), .iresps (fp_iresps),
    .oreq (fp_oreq), .oresp (oresp), .grant_valid (fp_gv), .grant_idx (fp_gi),
    .dbg_state (fp_state), .dbg_rr_ptr (fp_ptr)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  // Checkers
  task automatic chk_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input cbus_req_t obs, input cbus_req_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_resps(input string tag, input resp_vec_t obs, input resp_vec_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers and helpers
  function automatic cbus_req_t mk_req(input int idx, input logic [3:0] len);
    cbus_req_t r;
    r       = '0;
    r.valid = 1'b1;
    r.addr  = 32'h1000_0000 + 32'(idx) * 32'h100;
    r.size  = CBUS_SIZE_4B;
    r.len   = len;
    r.data  = 32'h5a00_0000 + 32'(idx);
    r.strb  = 4'hf;
    return r;
  endfunction

  function automatic resp_vec_t only(input int idx, input cbus_resp_t r);
    resp_vec_t v;
    v = '0;
    v[IW'(idx)] = r;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_resp(input logic ready, input logic last, input logic [31:0] data);
    oresp.ready = ready;
    oresp.last  = last;
    oresp.data  = data;
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    #1;
    chk_v("rst_gv", 32'(rr_gv), 0);
    chk_v("rst_gi", 32'(rr_gi), 0);
    chk_v("rst_state", 32'(rr_state), 32'(ARB_IDLE));
    chk_v("rst_ptr", 32'(rr_ptr), 0);
    chk_req("rst_oreq", rr_oreq, '0);
    chk_resps("rst_iresps", rr_iresps, '0);
    tick;
    resetn = 1'b1;
  endtask

  // Directed sequence
  initial begin
    resetn = 1'b0;
    ireqs  = '0;
    oresp  = '0;
    #3;
    chk_v("por_gv", 32'(rr_gv), 0);
    chk_v("por_fp_gv", 32'(fp_gv), 0);
    tick;
    resetn = 1'b1;

    // Single requester 2, 4-beat read
    ireqs[2] = mk_req(2, 4'd3);
    #1;
    chk_v("a_idle_gv", 32'(rr_gv), 0);
    chk_v("a_idle_oreq_valid", 32'(rr_oreq.valid), 0);
    tick;
    chk_v("a_gv", 32'(rr_gv), 1);
    chk_v("a_gi", 32'(rr_gi), 2);
    for (int b = 0; b < 4; b++) begin
      set_resp(1'b1, (b == 3), 32'hd000_0000 + 32'(b));
      #1;
      chk_req("a_oreq", rr_oreq, mk_req(2, 4'd3));
      chk_resps("a_iresps", rr_iresps, only(2, oresp));
      tick;
    end
    ireqs = '0;
    oresp = '0;
    #1;
    chk_v("a_after_gv", 32'(rr_gv), 0);
    chk_v("a_after_gi", 32'(rr_gi), 0);
    chk_v("a_after_ptr", 32'(rr_ptr), 3);
    chk_v("a_fp_ptr", 32'(fp_ptr), 0);

    // All four requesters, single-beat each, memory always ready+last
    do_reset;
    for (int i = 0; i < N; i++) ireqs[IW'(i)] = mk_req(i, 4'd0);
    set_resp(1'b1, 1'b1, 32'h0000_aaaa);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk_v("b_gap_gv", 32'(rr_gv), 0);
      chk_v("b_gap_fp_gv", 32'(fp_gv), 0);
      tick;
      chk_v("b_rr_gv", 32'(rr_gv), 1);
      chk_v("b_rr_gi", 32'(rr_gi), order_rr[k]);
      chk_v("b_fp_gi", 32'(fp_gi), 0);
      chk_resps("b_rr_iresps", rr_iresps, only(order_rr[k], oresp));
      tick;
    end
    ireqs = '0;
    oresp = '0;

    // Owner 1 in an 8-beat burst; requester 0 arrives at beat 2
    do_reset;
    ireqs[1] = mk_req(1, 4'd7);
    tick;
    chk_v("c_gi", 32'(rr_gi), 1);
    for (int b = 0; b < 8; b++) begin
      if (b == 2) ireqs[0] = mk_req(0, 4'd0);
      set_resp(1'b1, (b == 7), 32'hc000_0000 + 32'(b));
      #1;
      chk_resps("c_iresps", rr_iresps, only(1, oresp));
      chk_v("c_hold_gi", 32'(rr_gi), 1);
      tick;
    end
    ireqs[1] = '0;
    oresp = '0;
    #1;
    chk_v("c_gap_gv", 32'(rr_gv), 0);
    chk_v("c_gap_ptr", 32'(rr_ptr), 2);
    chk_resps("c_gap_iresps", rr_iresps, '0);
    tick;
    chk_v("c_next_gv", 32'(rr_gv), 1);
    chk_v("c_next_gi", 32'(rr_gi), 0);
    set_resp(1'b1, 1'b1, 32'h0000_c0c0);
    #1;
    chk_resps("c_next_iresps", rr_iresps, only(0, oresp));
    tick;
    ireqs = '0;
    oresp = '0;

    // Owner drops valid mid-transaction: grant held, valid=0 forwarded
    ireqs[3] = mk_req(3, 4'd1);
    tick;
    chk_v("f_gi", 32'(rr_gi), 3);
    ireqs[3].valid = 1'b0;
    set_resp(1'b1, 1'b1, 32'h0000_f00f);
    #1;
    chk_v("f_oreq_valid", 32'(rr_oreq.valid), 0);
    tick;
    chk_v("f_hold_gv", 32'(rr_gv), 1);
    chk_v("f_hold_gi", 32'(rr_gi), 3);
    ireqs[3].valid = 1'b1;
    tick;
    chk_v("f_rel_gv", 32'(rr_gv), 0);
    chk_v("f_wrap_ptr", 32'(rr_ptr), 0);
    ireqs = '0;
    oresp = '0;

    // last held with ready low for 3 cycles
    ireqs[2] = mk_req(2, 4'd0);
    tick;
    chk_v("d_gi", 32'(rr_gi), 2);
    for (int s = 0; s < 3; s++) begin
      set_resp(1'b0, 1'b1, 32'hbeef_0000 + 32'(s));
      #1;
      chk_resps("d_iresps", rr_iresps, only(2, oresp));
      tick;
      chk_v("d_stall_gv", 32'(rr_gv), 1);
      chk_v("d_stall_ptr", 32'(rr_ptr), 0);
    end
    oresp.ready = 1'b1;
    tick;
    chk_v("d_rel_gv", 32'(rr_gv), 0);
    chk_v("d_rel_ptr", 32'(rr_ptr), 3);
    ireqs = '0;
    oresp = '0;
    tick;
    chk_v("d_once_ptr", 32'(rr_ptr), 3);

    // Reset asserted mid-burst between edges
    ireqs[1] = mk_req(1, 4'd3);
    tick;
    chk_v("e_gi", 32'(rr_gi), 1);
    set_resp(1'b1, 1'b0, 32'he000_0000);
    tick;
    ireqs[3] = mk_req(3, 4'd0);
    #1;
    chk_v("e_busy_oreq_valid", 32'(rr_oreq.valid), 1);
    resetn = 1'b0;
    #1;
    chk_v("e_rst_oreq_valid", 32'(rr_oreq.valid), 0);
    chk_v("e_rst_gv", 32'(rr_gv), 0);
    chk_v("e_rst_ptr", 32'(rr_ptr), 0);
    chk_resps("e_rst_iresps", rr_iresps, '0);
    tick;
    resetn = 1'b1;
    oresp  = '0;
    #1;
    chk_v("e_idle_gv", 32'(rr_gv), 0);
    tick;
    chk_v("e_first_gv", 32'(rr_gv), 1);
    chk_v("e_first_gi", 32'(rr_gi), 1);
    ireqs = '0;
    tick;

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
